// File: rtl/wait_state_memory_pkg.sv
// Shared definitions for the wait-state memory: FSM states, counter width and
// the request-operation encoding captured at accept time.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int WAIT_CNT_W = 4;

   // Operation code is simply {write, read}, so both-set is the conflict case.
   localparam logic [1:0] OP_NONE     = 2'b00;
   localparam logic [1:0] OP_READ     = 2'b01;
   localparam logic [1:0] OP_WRITE    = 2'b10;
   localparam logic [1:0] OP_CONFLICT = 2'b11;

   function automatic logic [1:0] encode_op(input logic rd, input logic wr);
      return {wr, rd};
   endfunction

endpackage

// File: rtl/wait_state_memory_if.sv
// Request/response bus between a load/store unit (master) and the
// wait-state memory (slave).
interface wait_state_memory_if #(
   parameter int ADDR_W     = 32,
   parameter int DATA_BYTES = 4
) ();

   logic [ADDR_W-1:0]       req_addr;
   logic [8*DATA_BYTES-1:0] req_wdata;
   logic [DATA_BYTES-1:0]   req_be;
   logic                    req_read;
   logic                    req_write;
   logic                    req_ready;
   logic                    rsp_valid;
   logic [8*DATA_BYTES-1:0] rsp_rdata;
   logic                    rsp_err;

   modport master (
      output req_addr, req_wdata, req_be, req_read, req_write,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_addr, req_wdata, req_be, req_read, req_write,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/wait_state_memory_wait_counter.sv
// Loadable down-counter used to time the wait states between accepting a
// request and presenting its response. Holds at zero.
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] load_val,
   input  logic                  dec,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] count;

   // Load takes priority over decrement; the count never underflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/wait_state_memory.sv
// Byte-addressable data memory with programmable wait states and a
// request/response handshake. Words are little-endian, DATA_BYTES wide, and
// may start at any byte address.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag any byte beyond DEPTH
// as an error instead of wrapping the address around to byte 0.
module wait_state_memory
   import mem_pkg::*;
#(
   parameter int DATA_BYTES  = 4,
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 2,
   parameter     INIT_FILE   = "output.txt"
) (
   input logic                 clk,
   input logic                 rst_n,
   wait_state_memory_if.slave  bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

   logic [7:0] mem [0:DEPTH-1];

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q;
   logic [8*DATA_BYTES-1:0] wdata_q;
   logic [DATA_BYTES-1:0]   be_q;
   logic [1:0]              op_q;

   logic accept, cnt_load, cnt_dec, cnt_zero;
   logic ready_c, valid_c;
   logic addr_err, err_c;
   logic [8*DATA_BYTES-1:0] rdata_c;
   logic [DATA_BYTES-1:0][IDX_W-1:0] lane_idx;

   mem_wait_counter u_wait_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register; a reset mid-access drops the transaction entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; WAIT is skipped when there are no wait states.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      ready_c  = 1'b0;
      valid_c  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.req_read || bus.req_write) begin
               accept = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_d  = WAIT;
                  cnt_load = 1'b1;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               state_d = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP: begin
            valid_c = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture; the bus is free to change once the request is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         op_q    <= OP_NONE;
      end else if (accept) begin
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
         op_q    <= encode_op(bus.req_read, bus.req_write);
      end
   end

   // Per-lane byte address, computed one bit wider than the bus so the
   // carry out of the top is never lost.
`ifdef MEM_BOUNDS_CHECK_EN
   logic [DATA_BYTES-1:0] lane_oob;
`endif
   for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
      logic [ADDR_W:0] full_addr;
      assign full_addr   = {1'b0, addr_q} + (ADDR_W+1)'(i);
      assign lane_idx[i] = IDX_W'(full_addr % (ADDR_W+1)'(DEPTH));
`ifdef MEM_BOUNDS_CHECK_EN
      assign lane_oob[i] = (full_addr >= (ADDR_W+1)'(DEPTH));
`endif
   end

`ifdef MEM_BOUNDS_CHECK_EN
   assign addr_err = |lane_oob;
`else
   assign addr_err = 1'b0;
`endif

   assign err_c = (op_q == OP_CONFLICT) || addr_err;

   // Read data is assembled during RESP only and is zero for writes and errors.
   always_comb begin
      rdata_c = '0;
      if ((state_q == RESP) && (op_q == OP_READ) && !err_c) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            rdata_c[8*i +: 8] = mem[lane_idx[i]];
         end
      end
   end

   // Writes commit at the edge that ends RESP, so the next request sees them.
   always_ff @(posedge clk) begin
      if ((state_q == RESP) && (op_q == OP_WRITE) && !err_c) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (be_q[i]) begin
               mem[lane_idx[i]] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready = ready_c;
   assign bus.rsp_valid = valid_c;
   assign bus.rsp_rdata = rdata_c;
   assign bus.rsp_err   = valid_c && err_c;

endmodule

// File: tb/tb_wait_state_memory.sv
// Randomised scoreboard bench for wait_state_memory. A byte-array reference
// model predicts each response when the request is issued; a monitor pops
// predictions and compares them when rsp_valid is seen, including the cycle
// in which the response arrives. Builds with or without MEM_BOUNDS_CHECK_EN.
module tb_wait_state_memory;

   localparam int DATA_BYTES  = 4;
   localparam int DEPTH       = 256;
   localparam int ADDR_W      = 32;
   localparam int WAIT_CYCLES = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];
   logic [7:0] ref_mem [DEPTH];

   wait_state_memory_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES)) bus ();

   wait_state_memory #(
      .DATA_BYTES  (DATA_BYTES),
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES),
      .INIT_FILE   ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to check response latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: works on byte addresses directly and updates ref_mem for writes.
   function automatic void model(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input bit rd, input bit wr,
                                 output logic [31:0] rdata, output logic err);
      longint a;
      rdata = '0;
      err   = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      for (int i = 0; i < DATA_BYTES; i++) begin
         a = {32'h0, addr} + i;
         if (a >= DEPTH) err = 1'b1;
      end
`endif
      if (rd && wr) err = 1'b1;
      if (err) return;
      for (int i = 0; i < DATA_BYTES; i++) begin
         a = ({32'h0, addr} + i) % DEPTH;
         if (rd) rdata[8*i +: 8] = ref_mem[a];
         else if (be[i]) ref_mem[a] = wdata[8*i +: 8];
      end
   endfunction

   task automatic waitReady();
      int budget = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (bus.req_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL ready_timeout: got req_ready=%b required 1", bus.req_ready);
      end
   endtask

   // Issue one request, predict its response, optionally poke a request during the wait.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input bit rd, input bit wr, input bit poke);
      exp_t e;
      waitReady();
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      bus.req_read  = rd;
      bus.req_write = wr;
      model(addr, wdata, be, rd, wr, e.rdata, e.err);
      e.cyc = cyc + 1 + WAIT_CYCLES;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (poke) begin
         bus.req_addr  = addr ^ 32'h4;
         bus.req_read  = 1'b1;
         bus.req_write = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
      bus.req_be    = '0;
   endtask

   task automatic drain();
      int budget = 0;
      while (sb.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL drain: got %0d pending responses required 0", sb.size());
      end
   endtask

   // Monitor: every response pulse must match the oldest outstanding prediction.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 required 0");
         end else begin
            e = sb.pop_front();
            checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
            checkOutput("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
            checkOutput("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   // Main sequence: reset, preload, directed cases, mid-access reset, random traffic.
   initial begin
      logic [31:0] addr;
      int r;
      cyc = 0;
      n_tests = 0;
      n_fail = 0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("reset_valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("reset_rdata", bus.rsp_rdata, 32'h0);
      checkOutput("reset_err", {31'h0, bus.rsp_err}, 32'h0);
      rst_n = 1'b1;

      for (int a = 0; a < DEPTH; a += 4) applyStimulus(a, $urandom, 4'hF, 0, 1, 0);

      applyStimulus(32'h10, 32'h44332211, 4'hF, 0, 1, 0);
      applyStimulus(32'h10, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'h20, 32'h0, 4'hF, 0, 1, 0);
      applyStimulus(32'h20, 32'hAABBCCDD, 4'b0101, 0, 1, 0);
      applyStimulus(32'h20, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'hFE, 32'h01020304, 4'hF, 0, 1, 0);
      applyStimulus(32'hFC, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'hFE, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'h00, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'h30, 32'h12345678, 4'hF, 1, 1, 0);
      applyStimulus(32'h30, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'h34, 32'hFFFFFFFF, 4'h0, 0, 1, 0);
      applyStimulus(32'h34, 32'h0, 4'h0, 1, 0, 0);
      applyStimulus(32'h50, 32'hCAFEF00D, 4'hF, 0, 1, 1);
      applyStimulus(32'h50, 32'h0, 4'h0, 1, 0, 1);
      applyStimulus(32'h54, 32'h0, 4'h0, 1, 0, 0);

      waitReady();
      bus.req_addr  = 32'h60;
      bus.req_wdata = 32'hDEADBEEF;
      bus.req_be    = 4'hF;
      bus.req_write = 1'b1;
      @(posedge clk);
      #1;
      bus.req_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_valid", {31'h0, bus.rsp_valid}, 32'h0);
      checkOutput("midreset_ready", {31'h0, bus.req_ready}, 32'h1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(32'h60, 32'h0, 4'h0, 1, 0, 0);

      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 7);
         addr = (r == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
         r = $urandom_range(0, 9);
         applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)),
                       (r <= 4), (r == 0) || (r >= 5), ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
